// File: rtl/alu_multicycle_if.sv
// -----------------------------------------------------------------------------
// alu_multicycle_if
// Request/response bundle for the multicycle ALU.
//   start        - request strobe (master -> slave)
//   alu_control  - 4-bit opcode (master -> slave)
//   a, b         - WIDTH-bit operands (master -> slave)
//   alu_out      - registered result (slave -> master)
//   flagz/n/c/v/dz - registered zero/negative/carry/overflow/div-by-zero flags
//   busy         - multi-cycle operation in progress (slave -> master)
//   done         - one-cycle completion pulse (slave -> master)
// -----------------------------------------------------------------------------
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic             flagz;
  logic             flagn;
  logic             flagc;
  logic             flagv;
  logic             flagdz;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_control, a, b,
    input  alu_out, flagz, flagn, flagc, flagv, flagdz, busy, done
  );

  modport slave (
    input  start, alu_control, a, b,
    output alu_out, flagz, flagn, flagc, flagv, flagdz, busy, done
  );
endinterface

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// ALU with single-cycle logic/arithmetic ops and iterative MUL/DIVU/REMU.
//   clk    - clock, all state on rising edge
//   reset  - synchronous active-high reset
//   bus    - alu_multicycle_if.slave: start/alu_control/a/b in,
//            alu_out/flags/busy/done out (all outputs registered)
// Single-cycle ops complete on the accepting edge (done the next cycle).
// MUL (shift-add) and DIVU/REMU (restoring division) run WIDTH iterations
// in RUN and complete on the WIDTH-th edge after acceptance.
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_multicycle_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product (MUL) or partial remainder (DIV)
  // opa: shifting multiplicand (MUL) or divisor (DIV)
  // opb: shifting multiplier (MUL) or dividend/quotient shift register (DIV)
  logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic             is_div, is_multi;

  always_comb begin
    add_full = {1'b0, bus.a} + {1'b0, bus.b};
    sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    case (bus.alu_control)
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_NOR:  sc_res = ~(bus.a | bus.b);
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                 (add_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        // carry-out of a+~b+1 is 1 when there is no borrow
        sc_c   = ~sub_full[WIDTH];
        sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                 (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
      end
      // Direct compares, so signed SLT stays correct when a-b overflows
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      // Only reached here with b == 0 (divide-by-zero shortcut)
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = bus.a;
      default: sc_res = '0;
    endcase
    is_div   = (bus.alu_control == OP_DIVU) || (bus.alu_control == OP_REMU);
    is_multi = (bus.alu_control == OP_MUL) || (is_div && (bus.b != '0));
  end

  // One iteration of the multi-cycle datapath
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic [WIDTH-1:0] it_acc, it_opa, it_opb, it_res;

  always_comb begin
    rem_shift = {acc_q, opb_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opa_q};
    if (kind_q == K_MUL) begin
      it_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
      it_opa = opa_q << 1;
      it_opb = opb_q >> 1;
    end else begin
      it_opa = opa_q;
      // Restoring step: keep the difference only if it did not borrow
      if (!rem_diff[WIDTH]) begin
        it_acc = rem_diff[WIDTH-1:0];
        it_opb = {opb_q[WIDTH-2:0], 1'b1};
      end else begin
        it_acc = rem_shift[WIDTH-1:0];
        it_opb = {opb_q[WIDTH-2:0], 1'b0};
      end
    end
    it_res = (kind_q == K_DIVU) ? it_opb : it_acc;
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_multi) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            cnt_d   = CNT_INIT;
            acc_d   = '0;
            if (bus.alu_control == OP_MUL) begin
              kind_d = K_MUL;
              opa_d  = bus.a;
              opb_d  = bus.b;
            end else begin
              kind_d = (bus.alu_control == OP_DIVU) ? K_DIVU : K_REMU;
              opa_d  = bus.b;
              opb_d  = bus.a;
            end
          end else begin
            res_d  = sc_res;
            z_d    = (sc_res == '0);
            n_d    = sc_res[WIDTH-1];
            c_d    = sc_c;
            v_d    = sc_v;
            dz_d   = is_div;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // start is ignored here: busy is high for the whole run
        acc_d = it_acc;
        opa_d = it_opa;
        opb_d = it_opb;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = it_res;
          z_d     = (it_res == '0);
          n_d     = it_res[WIDTH-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
          dz_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.alu_out = res_q;
  assign bus.flagz   = z_q;
  assign bus.flagn   = n_q;
  assign bus.flagc   = c_q;
  assign bus.flagv   = v_q;
  assign bus.flagdz  = dz_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed test of alu_multicycle (WIDTH=32) with hand-computed vectors.
// Flags are compared packed as {z, n, c, v, dz}.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;
  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_ILL  = 4'b1011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_res   = '0;
  logic [4:0]   prev_flags = '0;
  logic [4:0]   flags_w;
  assign flags_w = {bus.flagz, bus.flagn, bus.flagc, bus.flagv, bus.flagdz};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
  endtask

  // Single-cycle op: done and result visible right after the accepting edge
  task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input logic [4:0] ef);
    drive(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    $display("txn %s: op=%b a=0x%08h b=0x%08h -> out=0x%08h flags=%b done=%b",
             tag, op, a, b, bus.alu_out, flags_w, bus.done);
    check({tag, ".done"}, 64'(bus.done), 64'(1'b1));
    check({tag, ".busy"}, 64'(bus.busy), 64'(1'b0));
    check({tag, ".out"}, 64'(bus.alu_out), 64'(exp));
    check({tag, ".flags"}, 64'(flags_w), 64'(ef));
    prev_res   = exp;
    prev_flags = ef;
  endtask

  // Multi-cycle op; inject > 0 issues a competing start before that run edge
  task automatic multi(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input logic [4:0] ef,
                       input int inject);
    drive(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".busy0"}, 64'(bus.busy), 64'(1'b1));
    check({tag, ".done0"}, 64'(bus.done), 64'(1'b0));
    for (int i = 1; i <= W; i++) begin
      if (i == inject) drive(OP_ADD, 32'h1, 32'h1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (i < W) begin
        check({tag, ".busy_run"}, 64'(bus.busy), 64'(1'b1));
        check({tag, ".done_run"}, 64'(bus.done), 64'(1'b0));
        check({tag, ".out_run"}, 64'(bus.alu_out), 64'(prev_res));
        check({tag, ".flags_run"}, 64'(flags_w), 64'(prev_flags));
      end
    end
    $display("txn %s: op=%b a=0x%08h b=0x%08h -> out=0x%08h flags=%b done=%b",
             tag, op, a, b, bus.alu_out, flags_w, bus.done);
    check({tag, ".done"}, 64'(bus.done), 64'(1'b1));
    check({tag, ".busy"}, 64'(bus.busy), 64'(1'b0));
    check({tag, ".out"}, 64'(bus.alu_out), 64'(exp));
    check({tag, ".flags"}, 64'(flags_w), 64'(ef));
    prev_res   = exp;
    prev_flags = ef;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_low"}, 64'(bus.done), 64'(1'b0));
    check({tag, ".out_hold"}, 64'(bus.alu_out), 64'(prev_res));
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.alu_control = 4'b0;
    bus.a           = '0;
    bus.b           = '0;
    reset           = 1'b1;
    // Reset overrides a pending start
    drive(OP_ADD, 32'h1, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rst.out", 64'(bus.alu_out), 64'h0);
    check("rst.flags", 64'(flags_w), 64'h0);
    check("rst.busy", 64'(bus.busy), 64'h0);
    check("rst.done", 64'(bus.done), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst.done", 64'(bus.done), 64'h0);

    single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b01010);
    idle_cycle("add_ovf");
    single("sub_eq", OP_SUB, 32'd5, 32'd5, 32'h0, 5'b10000);
    // back-to-back: issued in the cycle done=1
    single("sub_borrow", OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 5'b01100);
    idle_cycle("sub_borrow");

    multi("mul", OP_MUL, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 5'b01000, 5);
    idle_cycle("mul");
    multi("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 5'b00000, 0);
    multi("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 5'b00000, 0);
    single("divu_z", OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 5'b01001);
    single("remu_z", OP_REMU, 32'd9, 32'd0, 32'd9, 5'b00001);

    single("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 5'b00000);
    single("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 5'b10000);
    single("slt_min", OP_SLT, 32'h80000000, 32'h1, 32'h1, 5'b00000);
    single("slt_ovf", OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h0, 5'b10000);

    single("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000);
    single("or", OP_OR, 32'h000000F0, 32'h0000000F, 32'h000000FF, 5'b00000);
    single("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFFFFFF, 5'b01000);
    single("xor", OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 5'b00000);
    single("add_carry", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 5'b10100);
    single("add_negovf", OP_ADD, 32'h80000000, 32'h80000000, 32'h0, 5'b10110);
    single("xor2", OP_XOR, 32'h1, 32'h0, 32'h1, 5'b00000);
    single("illegal", OP_ILL, 32'd5, 32'd3, 32'h0, 5'b10000);
    multi("mul2", OP_MUL, 32'h12345678, 32'd9, 32'hA3D70A38, 5'b01000, 0);
    idle_cycle("mul2");

    // Reset in the 10th cycle of a MUL aborts it with no done pulse
    drive(OP_MUL, 32'h12345678, 32'd9);
    @(posedge clk); #1;
    bus.start = 1'b0;
    $display("txn mul_abort: MUL accepted, busy=%b", bus.busy);
    check("mul_abort.busy0", 64'(bus.busy), 64'h1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort.busy", 64'(bus.busy), 64'h0);
    check("abort.done", 64'(bus.done), 64'h0);
    check("abort.out", 64'(bus.alu_out), 64'h0);
    check("abort.flags", 64'(flags_w), 64'h0);
    prev_res   = '0;
    prev_flags = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", 64'({bus.done, bus.busy}), 64'h0);
    end
    check("abort.out_hold", 64'(bus.alu_out), 64'h0);
    single("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000);
    idle_cycle("add_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted on a rising edge where start=1 and busy=0.
REQ-005 alu_control  input  4  operation select, sampled only on the accepting edge.
REQ-006 a, b  input  WIDTH  operands, sampled only on the accepting edge.
REQ-007 alu_out  output  WIDTH  registered result, held until the next completion.
REQ-008 flagz, flagn, flagc, flagv, flagdz  output  1 each  registered zero, negative, carry/borrow, signed overflow, divide-by-zero flags.
REQ-009 busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking alu_out/flags update.

Function
REQ-011 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 MUL (low WIDTH bits of unsigned product), 0100 NOR, 0101 DIVU quotient, 0110 SUB, 0111 SLT signed, 1000 XOR, 1001 SLTU, 1010 REMU; 1011-1111 illegal.
REQ-012 States SHALL be IDLE and RUN; done is a registered pulse, not a state.
REQ-013 Single-cycle ops (all except MUL/DIVU/REMU) and illegal opcodes SHALL register result and flags on the accepting edge, done=1 for exactly the following cycle, state stays IDLE.
REQ-014 MUL SHALL use iterative shift-add, one operand bit per cycle; DIVU/REMU SHALL use iterative restoring division, one quotient bit per cycle.
REQ-015 MUL/DIVU/REMU with nonzero divisor SHALL go to RUN on the accepting edge with busy=1, iterate WIDTH cycles, and on the WIDTH-th edge after acceptance register result and flags, assert done, clear busy, return to IDLE.
REQ-016 alu_out, flags and done SHALL NOT change during RUN; intermediate values are never visible.
REQ-017 start while busy=1 SHALL be ignored with no effect on the running operation.
REQ-018 start may be accepted in the cycle done=1; a new single-cycle result then produces back-to-back done pulses.
REQ-019 DIVU/REMU with b=0 SHALL complete in one cycle: DIVU result all-ones, REMU result=a, flagdz=1.
REQ-020 flagdz SHALL be 0 for every other completion.
REQ-021 flagz=1 iff result==0; flagn=result[WIDTH-1], for every completion.
REQ-022 ADD: flagc = carry out of bit WIDTH-1; flagv = signed overflow (operands same sign, result sign differs).
REQ-023 SUB computes a+~b+1: flagc=1 iff borrow (a<b unsigned); flagv = signed overflow (operand signs differ, result sign differs from a).
REQ-024 SLT/SLTU result SHALL be 1 or 0 zero-extended to WIDTH; signed compare SHALL be correct even when a-b overflows.
REQ-025 flagc and flagv SHALL be 0 for all ops other than ADD and SUB.
REQ-026 Illegal opcodes SHALL produce result 0 (flagz=1), all other flags 0.
REQ-027 Iteration counter SHALL be clog2(WIDTH+1) bits; no wrap-around into a second pass.

Reset
REQ-028 With reset=1 at a rising edge: state=IDLE, busy=0, done=0, alu_out=0, all flags 0; reset overrides start.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse and no result update; a start accepted after reset deassertion behaves normally.

Verification
REQ-030 WIDTH=32, ADD a=0x7FFFFFFF b=1 -> next cycle done=1, alu_out=0x80000000, n=1 v=1 c=0 z=0.
REQ-031 SUB a=5 b=5 -> alu_out=0, z=1 c=0 v=0; SUB a=0 b=1 -> 0xFFFFFFFF, c=1 n=1.
REQ-032 MUL a=0x0000FFFF b=0x00010001 -> busy=1 for 32 cycles, done exactly 32 edges after acceptance, alu_out=0xFFFFFFFF; a start issued at cycle 5 of the run is ignored.
REQ-033 DIVU 100/7 -> 14, REMU 100/7 -> 2 (each 32-cycle latency); DIVU 9/0 -> 0xFFFFFFFF, dz=1, done after 1 cycle; REMU 9/0 -> 9, dz=1.
REQ-034 SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; SLT a=0x80000000 b=1 -> 1.
REQ-035 Reset asserted at cycle 10 of a MUL -> busy=0, alu_out=0, no done pulse; a following ADD 2+3 yields 5 with done one cycle later.
